// File: rtl/fir_mac_nch.sv
// fir_mac_nch: N-channel FIR multiply-accumulate engine.
// A run walks a shared coefficient ROM once and MACs every channel's streamed
// sample against the same coefficient. The engine then scales, saturates and
// presents the per-channel results with a one-cycle valid pulse.
module fir_mac_nch #(
  parameter int NUM_CH   = 2,
  parameter int NUM_TAPS = 1021,
  parameter int DW       = 16,
  parameter int CW       = 16,
  parameter int OW       = 16,
  parameter int SHIFT    = 15,
  parameter int AW       = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sequencing,
  input  logic [NUM_CH*DW-1:0] data_in,
  input  logic [CW-1:0]        coeff_in,
  output logic [AW-1:0]        addr,
  output logic [NUM_CH*OW-1:0] dout,
  output logic                 out_valid,
  output logic [NUM_CH-1:0]    sat,
  output logic                 busy
);

  localparam int PW    = DW + CW;
  localparam int ACC_W = DW + CW + $clog2(NUM_TAPS);
  localparam int TW    = $clog2(NUM_TAPS);

  localparam logic [TW-1:0] LAST_TAP  = TW'(NUM_TAPS - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_TAPS - 1);

  // Output clamp limits, sign-extended to accumulator width.
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_reg, state_next;
  logic          seq_q;
  logic          start;
  logic          acc_clr, acc_en, load_out;
  logic [TW-1:0] tap_cnt;

  assign start = sequencing & ~seq_q;

  // Edge detector for sequencing. Resetting to 1 means a level that is already
  // high when reset releases is not mistaken for a fresh rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seq_q <= 1'b1;
    else        seq_q <= sequencing;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next state and datapath strobes; dropping sequencing aborts RUN or DRAIN.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    load_out   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          acc_clr    = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (!sequencing) begin
          state_next = IDLE;
        end else begin
          acc_en = 1'b1;
          if (tap_cnt == LAST_TAP) state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy       = 1'b1;
        load_out   = sequencing;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ROM address and tap counter. The address leads the accumulate by one cycle
  // to cover the registered ROM read, and it sticks at the last tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr    <= '0;
      tap_cnt <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          tap_cnt <= '0;
          addr    <= start ? AW'(1) : '0;
        end
        RUN: begin
          if (!sequencing) begin
            addr <= '0;
          end else begin
            tap_cnt <= tap_cnt + TW'(1);
            if (addr != LAST_ADDR) addr <= addr + AW'(1);
          end
        end
        default: addr <= '0;
      endcase
    end
  end

  // Result strobe: high for the single cycle after dout is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_valid <= 1'b0;
    else        out_valid <= load_out;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic signed [DW-1:0]    sample;
      logic signed [PW-1:0]    prod;
      logic signed [ACC_W-1:0] acc_reg;
      logic signed [ACC_W-1:0] shifted;
      logic                    sat_hi, sat_lo;
      logic [OW-1:0]           clamped;
      logic [OW-1:0]           dout_reg;
      logic                    sat_reg;

      assign sample  = $signed(data_in[gi*DW +: DW]);
      assign prod    = sample * $signed(coeff_in);
      assign shifted = acc_reg >>> SHIFT;
      assign sat_hi  = shifted > OUT_MAX;
      assign sat_lo  = shifted < OUT_MIN;
      assign clamped = sat_hi ? OUT_MAX[OW-1:0] :
                       sat_lo ? OUT_MIN[OW-1:0] : shifted[OW-1:0];

      // Channel accumulator; the width covers the worst-case sum, so no wrap.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       acc_reg <= '0;
        else if (acc_clr) acc_reg <= '0;
        else if (acc_en)  acc_reg <= acc_reg + ACC_W'(prod);
      end

      // Scaled, saturated result and flag; both hold until the next completed run.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_reg <= '0;
          sat_reg  <= 1'b0;
        end else if (load_out) begin
          dout_reg <= clamped;
          sat_reg  <= sat_hi | sat_lo;
        end
      end

      assign dout[gi*OW +: OW] = dout_reg;
      assign sat[gi]           = sat_reg;
    end
  endgenerate

endmodule

// File: tb/tb_fir_mac_nch.sv
// Testbench for fir_mac_nch: 2 channels, 8 taps, 16-bit data/coeff/output.
module tb_fir_mac_nch;

  localparam int NT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sequencing = 1'b0;
  logic [31:0] data_in = '0;
  logic [15:0] coeff_in = '0;
  logic [3:0]  addr;
  logic [31:0] dout;
  logic        out_valid;
  logic [1:0]  sat;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [15:0] rom [16];
  logic [15:0] smp [2][NT];
  logic [31:0] last_dout = '0;
  logic [1:0]  last_sat = '0;

  typedef struct {
    logic [15:0] coeff;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [31:0] exp_dout;
    logic [1:0]  exp_sat;
  } vec_t;

  vec_t vecs [3];

  fir_mac_nch #(
    .NUM_CH(2), .NUM_TAPS(NT), .DW(16), .CW(16), .OW(16), .SHIFT(15), .AW(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sequencing(sequencing), .data_in(data_in),
    .coeff_in(coeff_in), .addr(addr), .dout(dout), .out_valid(out_valid),
    .sat(sat), .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered coefficient ROM, one-cycle read latency.
  always @(posedge clk) coeff_in <= rom[addr];

  // The address must never pass the last tap.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (addr > 4'(NT - 1)) begin
        failures++;
        $display("FAIL addr_range actual=%0d required<=%0d", addr, NT - 1);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: FIR sum with integer arithmetic, then shift and clamp.
  task automatic model(output logic [31:0] ed, output logic [1:0] es);
    for (int c = 0; c < 2; c++) begin
      longint acc = 0;
      longint s;
      for (int k = 0; k < NT; k++)
        acc += longint'($signed(rom[k])) * longint'($signed(smp[c][k]));
      s = acc >>> 15;
      es[c] = 1'b0;
      if (s > 32767)  begin s = 32767;  es[c] = 1'b1; end
      if (s < -32768) begin s = -32768; es[c] = 1'b1; end
      ed[c*16 +: 16] = 16'(s);
    end
  endtask

  task automatic fill_const(input logic [15:0] cf, input logic [15:0] d0, input logic [15:0] d1);
    for (int k = 0; k < NT; k++) begin
      rom[k] = cf;
      smp[0][k] = d0;
      smp[1][k] = d1;
    end
  endtask

  // Full run: start, stream samples, check trace and result, hold high to
  // confirm no retrigger, then drop sequencing.
  task automatic do_run(input string tag, input logic [31:0] ed, input logic [1:0] es, input int hold);
    @(negedge clk) sequencing = 1'b1;
    @(posedge clk) #1;
    data_in = {smp[1][0], smp[0][0]};
    chk({tag, "_addr_e0"}, addr, 1);
    chk({tag, "_busy_e0"}, busy, 1);
    for (int k = 1; k <= NT; k++) begin
      @(posedge clk) #1;
      if (k < NT) data_in = {smp[1][k], smp[0][k]};
      chk($sformatf("%s_addr_e%0d", tag, k), addr, (k + 1 < NT) ? k + 1 : NT - 1);
      chk($sformatf("%s_valid_e%0d", tag, k), out_valid, 0);
      chk($sformatf("%s_busy_e%0d", tag, k), busy, 1);
    end
    @(posedge clk) #1;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_dout"}, dout, ed);
    chk({tag, "_sat"}, sat, es);
    chk({tag, "_addr_end"}, addr, 0);
    chk({tag, "_busy_end"}, busy, 0);
    last_dout = ed;
    last_sat = es;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk) #1;
      chk($sformatf("%s_noretrig%0d", tag, i), out_valid, 0);
      chk($sformatf("%s_idle%0d", tag, i), busy, 0);
    end
    @(negedge clk) sequencing = 1'b0;
  endtask

  initial begin
    logic [31:0] ed;
    logic [1:0]  es;

    vecs[0] = '{16'h4000, 16'h1000, 16'h1000, 32'h4000_4000, 2'b00};
    vecs[1] = '{16'h4000, 16'h1000, 16'hF000, 32'hC000_4000, 2'b00};
    vecs[2] = '{16'h7FFF, 16'h7FFF, 16'h8000, 32'h8000_7FFF, 2'b11};
    for (int a = 0; a < 16; a++) rom[a] = 16'h1357;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", addr, 0);
    chk("rst_dout", dout, 0);
    chk("rst_sat", sat, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed vectors
    for (int v = 0; v < 3; v++) begin
      fill_const(vecs[v].coeff, vecs[v].d0, vecs[v].d1);
      do_run($sformatf("vec%0d", v), vecs[v].exp_dout, vecs[v].exp_sat, (v == 0) ? 4 : 1);
      $display("vec%0d dout=%h sat=%b", v, dout, sat);
    end

    // Re-establish 0x4000 results, then abort a saturating run after 4 taps.
    fill_const(vecs[0].coeff, vecs[0].d0, vecs[0].d1);
    do_run("pre_abort", vecs[0].exp_dout, vecs[0].exp_sat, 1);
    fill_const(16'h7FFF, 16'h7FFF, 16'h8000);
    @(negedge clk) sequencing = 1'b1;
    @(posedge clk) #1;
    data_in = {smp[1][0], smp[0][0]};
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk) #1;
      data_in = {smp[1][k], smp[0][k]};
    end
    @(negedge clk) sequencing = 1'b0;
    @(posedge clk) #1;
    chk("abort_busy", busy, 0);
    chk("abort_addr", addr, 0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk) #1;
      chk($sformatf("abort_novalid%0d", i), out_valid, 0);
    end
    chk("abort_dout_hold", dout, last_dout);
    chk("abort_sat_hold", sat, last_sat);
    $display("abort dout=%h busy=%b", dout, busy);

    // Asynchronous reset in the middle of a run.
    fill_const(16'h2000, 16'h0800, 16'hF800);
    @(negedge clk) sequencing = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_dout", dout, 0);
    chk("midrst_addr", addr, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_sat", sat, 0);
    sequencing = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    $display("midrst dout=%h addr=%0d busy=%b", dout, addr, busy);
    fill_const(vecs[0].coeff, vecs[0].d0, vecs[0].d1);
    do_run("post_rst", 32'h4000_4000, 2'b00, 1);
    $display("post_rst dout=%h sat=%b", dout, sat);

    // Randomized runs against the reference model
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NT; k++) begin
        rom[k] = 16'($urandom);
        smp[0][k] = 16'($urandom);
        smp[1][k] = (r % 3 == 0) ? 16'h8000 : 16'($urandom);
      end
      model(ed, es);
      do_run($sformatf("rnd%0d", r), ed, es, 0);
      $display("rnd%0d dout=%h sat=%b exp=%h/%b", r, dout, sat, ed, es);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
